// File: rtl/lr_pkg.sv
// ---------------------------------------------------------------------------
// lr_pkg
// Shared definitions for the logistic-regression datapath: vector geometry,
// sample width, the feature/vector types and the feature_vector_buffer
// fill-FSM state encoding.
// ---------------------------------------------------------------------------
package lr_pkg;

    localparam int FEAT_W = 32;                 // sample width
    localparam int NFEAT  = 41;                 // total vector entries
    localparam int FIRST  = 2;                  // first streamed entry
    localparam int NS     = NFEAT - FIRST;      // streamed samples per vector
    localparam int CNT_W  = $clog2(NS);

    typedef logic [FEAT_W-1:0] feat_t;
    typedef feat_t [0:NFEAT-1] fvec_t;
    typedef logic  [CNT_W-1:0] cnt_t;

    localparam feat_t BIAS     = 32'd1;         // value of entry 0
    localparam cnt_t  CNT_LAST = cnt_t'(NS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fvb_state_t;

endpackage

// File: rtl/feature_vector_buffer.sv
// ---------------------------------------------------------------------------
// feature_vector_buffer
// Gathers NS streamed feature samples into entries FIRST..NFEAT-1 of a
// feature vector and presents the whole vector on xarray. A fill bank
// collects the next vector while the output bank holds the presented one.
//
// Optional build macro: FVB_LAST_CHECK_EN enables s_last framing checks and
// the sticky err_len output.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   s_data          feature sample
//   s_valid/s_ready sample handshake
//   s_last          end-of-vector marker (checked only with FVB_LAST_CHECK_EN)
//   xarray          presented vector {BIAS, 0.., samples}
//   v_valid/v_ready vector handshake
//   err_len         sticky framing error (only with FVB_LAST_CHECK_EN)
//   dbg_state       current fill-FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable; xarray is
// held stable while v_valid is high and v_ready is low. s_ready never
// depends on s_valid; in HOLD it follows v_ready so the fill bank can start
// refilling in the same cycle the output bank is released.
// ---------------------------------------------------------------------------
module feature_vector_buffer
    import lr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  feat_t      s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_last,
    output fvec_t      xarray,
    output logic       v_valid,
    input  logic       v_ready,
`ifdef FVB_LAST_CHECK_EN
    output logic       err_len,
`endif
    output fvb_state_t dbg_state
);

    feat_t      fill_bank [NS];
    feat_t      out_bank  [NS];
    feat_t      copy_src  [NS];
    fvb_state_t state;
    cnt_t       cnt;

    logic accept;
    logic last_slot;
    logic out_free;
    logic early_end;
    logic do_copy;

    assign s_ready   = (state == FILL) || (v_valid && v_ready);
    assign accept    = s_valid && s_ready;
    assign last_slot = (cnt == CNT_LAST);
    assign out_free  = !v_valid || v_ready;
    assign dbg_state = state;

`ifdef FVB_LAST_CHECK_EN
    // s_last before the final slot abandons the partial vector.
    assign early_end = accept && s_last && !last_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
        end else if (accept && (s_last != last_slot)) begin
            err_len <= 1'b1;
        end
    end
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign early_end     = 1'b0;
`endif

    // Copy from FILL happens on the completing accept, so the final sample
    // is taken straight from s_data; in HOLD the fill bank is already full.
    assign do_copy = ((state == FILL) && accept && last_slot && out_free) ||
                     ((state == HOLD) && v_valid && v_ready);

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            copy_src[i] = fill_bank[i];
        end
        if (state == FILL) begin
            copy_src[NS-1] = s_data;
        end
    end

    // Sample storage needs no reset: a discarded partial vector is simply
    // overwritten, and cnt alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_bank[cnt] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            cnt     <= '0;
            v_valid <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                out_bank[i] <= '0;
            end
        end else begin
            if (do_copy) begin
                for (int i = 0; i < NS; i++) begin
                    out_bank[i] <= copy_src[i];
                end
            end

            if (do_copy) begin
                v_valid <= 1'b1;
            end else if (v_valid && v_ready) begin
                v_valid <= 1'b0;
            end

            if (accept) begin
                if (early_end || last_slot) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            case (state)
                FILL: begin
                    if (accept && last_slot && !out_free) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (v_valid && v_ready) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    always_comb begin
        xarray    = '0;
        xarray[0] = BIAS;
        for (int i = 0; i < NS; i++) begin
            xarray[FIRST + i] = out_bank[i];
        end
    end

endmodule

// File: tb/tb_feature_vector_buffer.sv
// ---------------------------------------------------------------------------
// tb_feature_vector_buffer
// Directed bench for feature_vector_buffer. A model built from accepted
// samples (grouped into vectors of NS) predicts v_valid, s_ready, xarray and
// err_len every cycle; literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_feature_vector_buffer;
    import lr_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    feat_t      s_data  = '0;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       v_ready = 1'b0;
    logic       s_ready;
    logic       v_valid;
    fvec_t      xarray;
    fvb_state_t dbg_state;
`ifdef FVB_LAST_CHECK_EN
    logic       err_len;
`endif

    always #5 clk = ~clk;

    feature_vector_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .xarray    (xarray),
        .v_valid   (v_valid),
        .v_ready   (v_ready),
`ifdef FVB_LAST_CHECK_EN
        .err_len   (err_len),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int    n_cmp  = 0;
    int    n_fail = 0;
    fvec_t exp_q[$];      // complete vectors not yet consumed
    feat_t part_q[$];     // samples of the vector being collected
    logic  err_exp = 1'b0;
    logic  stalled = 1'b0;
    fvec_t prev_x;
    int    tb_pos  = 0;   // driver's position inside the current vector

    task automatic check1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input fvec_t got, input fvec_t exp);
        int first_bad;
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            first_bad = -1;
            for (int i = 0; i < NFEAT; i++) begin
                if (first_bad < 0 && got[i] !== exp[i]) first_bad = i;
            end
            $display("FAIL %s: entry %0d got %h expected %h at %0t",
                     name, first_bad, got[first_bad], exp[first_bad], $time);
        end
    endtask

    // Model of one accepted sample: vectors are consecutive groups of NS.
    task automatic model_accept(input feat_t d, input logic last);
        fvec_t v;
`ifdef FVB_LAST_CHECK_EN
        if (last && part_q.size() != NS - 1) begin
            err_exp = 1'b1;
            part_q.delete();
            return;
        end
        if (!last && part_q.size() == NS - 1) err_exp = 1'b1;
`endif
        part_q.push_back(d);
        if (part_q.size() == NS) begin
            v    = '0;
            v[0] = BIAS;
            for (int i = 0; i < NS; i++) v[FIRST + i] = part_q[i];
            exp_q.push_back(v);
            part_q.delete();
        end
    endtask

    // Compare process: inputs are stable at the falling edge, so checks here
    // see the state the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            check1("reset_v_valid", v_valid, 1'b0);
            exp_q.delete();
            part_q.delete();
            err_exp = 1'b0;
            stalled = 1'b0;
        end else begin
            check1("v_valid", v_valid, exp_q.size() > 0);
            check1("s_ready", s_ready, (exp_q.size() < 2) || v_ready);
            if (v_valid && exp_q.size() > 0) check_vec("xarray", xarray, exp_q[0]);
            if (stalled) check_vec("xarray_stable", xarray, prev_x);
`ifdef FVB_LAST_CHECK_EN
            check1("err_len", err_len, err_exp);
`endif
            stalled = v_valid && !v_ready;
            prev_x  = xarray;
            if (v_valid && v_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (s_valid && s_ready) model_accept(s_data, s_last);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer n samples base+k; s_last follows the vector position unless
    // overridden by early_at (index within this call) or drop_last.
    task automatic send(input int n, input feat_t base, input int sv_pct,
                        input int vr_pct, input int early_at, input bit drop_last);
        int k      = 0;
        int waited = 0;
        while (k < n) begin
            s_valid = ($urandom_range(99) < sv_pct);
            v_ready = ($urandom_range(99) < vr_pct);
            s_data  = base + feat_t'(k);
            s_last  = (k == early_at) || (!drop_last && tb_pos == NS - 1);
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (s_last && tb_pos != NS - 1) tb_pos = 0;
                else tb_pos = (tb_pos + 1) % NS;
                k++;
                waited = 0;
            end else begin
                waited++;
                if (waited > 1000) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL send_timeout: accepted %0d expected %0d", k, n);
                    k = n;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        v_ready = 1'b1;
        repeat (4) step();
        v_ready = 1'b0;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check1("rst_v_valid", v_valid, 1'b0);
        check32("rst_x0", xarray[0], 32'd1);
        check32("rst_x2", xarray[2], 32'd0);
        check32("rst_x40", xarray[40], 32'd0);
        rst_n = 1'b1;
        #1;
        check1("rst_s_ready", s_ready, 1'b1);
        step();

        // 39 back-to-back samples 2..40, consumer always ready
        send(NS, 32'd2, 100, 100, -1, 1'b0);
        check1("t1_v_valid", v_valid, 1'b1);
        check32("t1_x0", xarray[0], 32'd1);
        check32("t1_x1", xarray[1], 32'd0);
        check32("t1_x2", xarray[2], 32'd2);
        check32("t1_x40", xarray[40], 32'd40);
        drain();

        // Consumer stalled: two vectors 100..138 and 139..177 -> HOLD
        send(2 * NS, 32'd100, 100, 0, -1, 1'b0);
        check1("t2_s_ready_hold", s_ready, 1'b0);
        check32("t2_state_hold", 32'(dbg_state), 32'(HOLD));
        check32("t2_x2", xarray[2], 32'd100);
        check32("t2_x40", xarray[40], 32'd138);
        repeat (2) step();
        v_ready = 1'b1;
        step();
        v_ready = 1'b0;
        #1;
        check1("t2_v_valid_cont", v_valid, 1'b1);
        check32("t2_second_x2", xarray[2], 32'd139);
        check32("t2_second_x40", xarray[40], 32'd177);
        check1("t2_s_ready_back", s_ready, 1'b1);
        check32("t2_state_fill", 32'(dbg_state), 32'(FILL));
        drain();

        // Random flow control over 20 vectors, sample = global index
        send(20 * NS, 32'd0, 50, 30, -1, 1'b0);
        drain();

        // Reset after 17 accepts discards the partial vector
        send(17, 32'd7000, 100, 0, -1, 1'b0);
        rst_n  = 1'b0;
        tb_pos = 0;
        repeat (2) step();
        check1("t4_rst_v_valid", v_valid, 1'b0);
        rst_n = 1'b1;
        step();
        send(NS, 32'hA5A5_0000, 100, 0, -1, 1'b0);
        check1("t4_v_valid", v_valid, 1'b1);
        check32("t4_x2", xarray[2], 32'hA5A5_0000);
        check32("t4_x40", xarray[40], 32'hA5A5_0026);
        drain();

        // Completing accept in the same cycle the previous vector is taken
        send(NS, 32'd5000, 100, 0, -1, 1'b0);
        send(NS - 1, 32'd5039, 100, 0, -1, 1'b0);
        send(1, 32'd5077, 100, 100, -1, 1'b0);
        v_ready = 1'b0;
        #1;
        check1("t5_no_bubble", v_valid, 1'b1);
        check32("t5_x2", xarray[2], 32'd5039);
        check32("t5_x40", xarray[40], 32'd5077);
        drain();

`ifdef FVB_LAST_CHECK_EN
        // Early s_last on the 10th sample
        check1("t6_err_clear", err_len, 1'b0);
        send(10, 32'd8000, 100, 100, 9, 1'b0);
        step();
        check1("t6_err_early", err_len, 1'b1);
        check1("t6_no_vector", v_valid, 1'b0);
        send(NS, 32'd9000, 100, 0, -1, 1'b0);
        check1("t6_v_valid", v_valid, 1'b1);
        check32("t6_x2", xarray[2], 32'd9000);
        drain();
        // Missing s_last on the 39th sample
        rst_n  = 1'b0;
        tb_pos = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check1("t6_err_reset", err_len, 1'b0);
        send(NS, 32'd9500, 100, 0, -1, 1'b1);
        check1("t6_miss_v_valid", v_valid, 1'b1);
        check1("t6_err_missing", err_len, 1'b1);
        check32("t6_miss_x40", xarray[40], 32'd9538);
        drain();
`endif

        check32("end_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
